mc_controller: RTL and testbench

MC_CONTROLLER -- requirements
Module: mc_controller

---
 rtl/mc_controller_pkg.sv | 106 ++++++++++
 rtl/mc_controller_alu_decoder.sv | 46 ++++
 rtl/mc_controller.sv | 62 ++++++
 tb/tb_mc_controller.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/mc_controller_pkg.sv
// Shared types, codes and FSM helper functions for the multicycle controller.
package mc_controller_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECUTER, EXECUTEI, ALUWB, BRANCH
  } state_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] OP_DP    = 2'b00;
  localparam logic [1:0] OP_MEM   = 2'b01;
  localparam logic [1:0] OP_BR    = 2'b10;
  localparam logic [1:0] OP_UNDEF = 2'b11;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  typedef struct packed {
    logic       next_pc;
    logic       ir_write;
    logic       adr_src;
    logic [1:0] result_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       reg_w;
    logic       mem_w;
    logic       alu_op;
    logic       branch;
  } ctrl_t;

  function automatic state_t next_state(state_t s, logic [1:0] op, logic [5:0] funct);
    state_t n;
    n = FETCH;
    case (s)
      FETCH: n = DECODE;
      DECODE: begin
        case (op)
          OP_MEM:  n = MEMADR;
          OP_DP:   n = funct[5] ? EXECUTEI : EXECUTER;
          OP_BR:   n = BRANCH;
          default: n = FETCH;
        endcase
      end
      MEMADR:             n = funct[0] ? MEMREAD : MEMWRITE;
      MEMREAD:            n = MEMWB;
      EXECUTER, EXECUTEI: n = ALUWB;
      default:            n = FETCH;
    endcase
    return n;
  endfunction

  function automatic ctrl_t state_ctrl(state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.ir_write   = 1'b1;
        c.next_pc    = 1'b1;
        c.alu_src_a  = 1'b1;
        c.alu_src_b  = SRCB_FOUR;
        c.result_src = RES_ALURESULT;
      end
      DECODE: begin
        c.alu_src_a  = 1'b1;
        c.alu_src_b  = SRCB_FOUR;
        c.result_src = RES_ALURESULT;
      end
      MEMADR:  c.alu_src_b = SRCB_IMM;
      MEMREAD: c.adr_src = 1'b1;
      MEMWB: begin
        c.result_src = RES_DATA;
        c.reg_w      = 1'b1;
      end
      MEMWRITE: begin
        c.adr_src = 1'b1;
        c.mem_w   = 1'b1;
      end
      EXECUTER: begin
        c.alu_op    = 1'b1;
        c.alu_src_b = SRCB_REG;
      end
      EXECUTEI: begin
        c.alu_op    = 1'b1;
        c.alu_src_b = SRCB_IMM;
      end
      ALUWB: c.reg_w = 1'b1;
      BRANCH: begin
        c.alu_src_b  = SRCB_IMM;
        c.result_src = RES_ALURESULT;
        c.branch     = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mc_controller_alu_decoder.sv
// ALU operation and flag-write decode from the data-processing cmd/S fields.
module alu_decoder
  import mc_controller_pkg::*;
(
  input  logic       alu_op,
  input  logic [5:0] funct,
  output logic [1:0] alu_control,
  output logic [1:0] flag_w,
  output logic       no_write
);

  logic [3:0] cmd;
  logic       s_bit;
  logic       supported;

  assign cmd   = funct[4:1];
  assign s_bit = funct[0];

  always_comb begin
    alu_control = ALU_ADD;
    no_write    = 1'b0;
    supported   = 1'b0;
    if (alu_op) begin
      supported = 1'b1;
      case (cmd)
        4'b0100: alu_control = ALU_ADD;
        4'b0010: alu_control = ALU_SUB;
        4'b0000: alu_control = ALU_AND;
        4'b1100: alu_control = ALU_ORR;
        4'b1010: begin
          alu_control = ALU_SUB;
          no_write    = 1'b1;
        end
        default: supported = 1'b0;
      endcase
    end
  end

  // Carry/overflow only make sense for the arithmetic operations.
  always_comb begin
    flag_w    = 2'b00;
    flag_w[1] = supported & s_bit;
    flag_w[0] = supported & s_bit & ((alu_control == ALU_ADD) || (alu_control == ALU_SUB));
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle Moore controller: state register with registered per-state controls.
module mc_controller
  import mc_controller_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] op,
  input  logic [5:0] funct,
  input  logic [3:0] rd,
  output logic       pcs,
  output logic       reg_w,
  output logic       mem_w,
  output logic [1:0] flag_w,
  output logic       no_write,
  output logic       next_pc,
  output logic       ir_write,
  output logic       adr_src,
  output logic [1:0] result_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_control,
  output logic [1:0] imm_src,
  output logic [1:0] reg_src,
  output logic [3:0] state_dbg
);

  state_t state;
  ctrl_t  ctrl;

  // Controls are registered from the next state so they line up with the state itself.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FETCH;
      ctrl  <= state_ctrl(FETCH);
    end else begin
      state <= next_state(state, op, funct);
      ctrl  <= state_ctrl(next_state(state, op, funct));
    end
  end

  alu_decoder u_alu_decoder (
    .alu_op      (ctrl.alu_op),
    .funct       (funct),
    .alu_control (alu_control),
    .flag_w      (flag_w),
    .no_write    (no_write)
  );

  assign reg_w      = ctrl.reg_w;
  assign mem_w      = ctrl.mem_w;
  assign next_pc    = ctrl.next_pc;
  assign ir_write   = ctrl.ir_write;
  assign adr_src    = ctrl.adr_src;
  assign result_src = ctrl.result_src;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign pcs        = (ctrl.reg_w & (rd == 4'd15)) | ctrl.branch;
  assign imm_src    = op;
  assign reg_src    = {(op == OP_MEM), (op == OP_BR)};
  assign state_dbg  = state;

endmodule

// File: tb/tb_mc_controller.sv
// Table-driven bench for mc_controller: per-cycle state/output vectors plus reset and latency sequences.
module tb_mc_controller;
  import mc_controller_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic       pcs, reg_w, mem_w, no_write, next_pc, ir_write, adr_src, alu_src_a;
  logic [1:0] flag_w, result_src, alu_src_b, alu_control, imm_src, reg_src;
  logic [3:0] state_dbg;

  int errors = 0;
  int checks = 0;

  mc_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .rd(rd),
    .pcs(pcs), .reg_w(reg_w), .mem_w(mem_w), .flag_w(flag_w), .no_write(no_write),
    .next_pc(next_pc), .ir_write(ir_write), .adr_src(adr_src), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
    .imm_src(imm_src), .reg_src(reg_src), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  logic [15:0] dut_vec;
  assign dut_vec = {pcs, reg_w, mem_w, flag_w, no_write, next_pc, ir_write,
                    adr_src, result_src, alu_src_a, alu_src_b, alu_control};

  function automatic logic [15:0] pk(logic p, logic rw, logic mw, logic [1:0] fw, logic nw,
                                     logic np, logic iw, logic ad, logic [1:0] rs,
                                     logic sa, logic [1:0] sb, logic [1:0] ac);
    return {p, rw, mw, fw, nw, np, iw, ad, rs, sa, sb, ac};
  endfunction

  typedef struct {
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  rd;
    state_t      st;
    logic [15:0] outs;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input int idx, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", name, idx, got, exp);
    end
  endtask

  task automatic add_instr(input logic [1:0] o, input logic [5:0] f, input logic [3:0] r,
                           input state_t s2, input logic [15:0] v2,
                           input state_t s3, input logic [15:0] v3,
                           input state_t s4, input logic [15:0] v4, input int n);
    logic [15:0] vf, vd;
    vf = pk(0,0,0,2'b00,0,1,1,0,2'b10,1,2'b10,2'b00);
    vd = pk(0,0,0,2'b00,0,0,0,0,2'b10,1,2'b10,2'b00);
    tbl.push_back('{o, f, r, FETCH, vf});
    tbl.push_back('{o, f, r, DECODE, vd});
    if (n > 2) tbl.push_back('{o, f, r, s2, v2});
    if (n > 3) tbl.push_back('{o, f, r, s3, v3});
    if (n > 4) tbl.push_back('{o, f, r, s4, v4});
  endtask

  task automatic run_latency(input logic [1:0] o, input logic [5:0] f, input int exp_cycles);
    int n;
    op = o; funct = f; rd = 4'd1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (state_dbg != FETCH && n < 12);
    chk("latency", int'(o), 16'(n), 16'(exp_cycles));
  endtask

  initial begin
    logic [15:0] v_fetch, v_e0, v_w, v_w15, v_ma, v_mr, v_mw, v_mw15, v_mwr, v_br;
    logic [15:0] v_orr, v_and, v_sub, v_cmp;
    v_fetch = pk(0,0,0,2'b00,0,1,1,0,2'b10,1,2'b10,2'b00);
    v_e0    = pk(0,0,0,2'b00,0,0,0,0,2'b00,0,2'b00,2'b00);
    v_w     = pk(0,1,0,2'b00,0,0,0,0,2'b00,0,2'b00,2'b00);
    v_w15   = pk(1,1,0,2'b00,0,0,0,0,2'b00,0,2'b00,2'b00);
    v_ma    = pk(0,0,0,2'b00,0,0,0,0,2'b00,0,2'b01,2'b00);
    v_mr    = pk(0,0,0,2'b00,0,0,0,1,2'b00,0,2'b00,2'b00);
    v_mw    = pk(0,1,0,2'b00,0,0,0,0,2'b01,0,2'b00,2'b00);
    v_mw15  = pk(1,1,0,2'b00,0,0,0,0,2'b01,0,2'b00,2'b00);
    v_mwr   = pk(0,0,1,2'b00,0,0,0,1,2'b00,0,2'b00,2'b00);
    v_br    = pk(1,0,0,2'b00,0,0,0,0,2'b10,0,2'b01,2'b00);
    v_orr   = pk(0,0,0,2'b10,0,0,0,0,2'b00,0,2'b00,2'b11);
    v_and   = pk(0,0,0,2'b10,0,0,0,0,2'b00,0,2'b00,2'b10);
    v_sub   = pk(0,0,0,2'b11,0,0,0,0,2'b00,0,2'b00,2'b01);
    v_cmp   = pk(0,0,0,2'b11,1,0,0,0,2'b00,0,2'b01,2'b01);

    add_instr(2'b00, 6'b001000, 4'd3,  EXECUTER, v_e0,  ALUWB,   v_w,   FETCH, 16'h0, 4);
    add_instr(2'b00, 6'b011001, 4'd4,  EXECUTER, v_orr, ALUWB,   v_w,   FETCH, 16'h0, 4);
    add_instr(2'b00, 6'b000001, 4'd5,  EXECUTER, v_and, ALUWB,   v_w,   FETCH, 16'h0, 4);
    add_instr(2'b00, 6'b000101, 4'd6,  EXECUTER, v_sub, ALUWB,   v_w,   FETCH, 16'h0, 4);
    add_instr(2'b00, 6'b000011, 4'd7,  EXECUTER, v_e0,  ALUWB,   v_w,   FETCH, 16'h0, 4);
    add_instr(2'b00, 6'b110101, 4'd0,  EXECUTEI, v_cmp, ALUWB,   v_w,   FETCH, 16'h0, 4);
    add_instr(2'b01, 6'b011001, 4'd2,  MEMADR,   v_ma,  MEMREAD, v_mr,  MEMWB, v_mw, 5);
    add_instr(2'b01, 6'b011000, 4'd2,  MEMADR,   v_ma,  MEMWRITE, v_mwr, FETCH, 16'h0, 4);
    add_instr(2'b10, 6'b000000, 4'd0,  BRANCH,   v_br,  FETCH,   16'h0, FETCH, 16'h0, 3);
    add_instr(2'b11, 6'b000000, 4'd0,  FETCH,    16'h0, FETCH,   16'h0, FETCH, 16'h0, 2);
    add_instr(2'b00, 6'b001000, 4'd15, EXECUTER, v_e0,  ALUWB,   v_w15, FETCH, 16'h0, 4);
    add_instr(2'b01, 6'b011001, 4'd15, MEMADR,   v_ma,  MEMREAD, v_mr,  MEMWB, v_mw15, 5);

    // Reset state
    reset = 1'b1; op = 2'b00; funct = 6'b0; rd = 4'd0;
    #1;
    chk("reset_state", 0, 16'(state_dbg), 16'(FETCH));
    chk("reset_outs", 0, dut_vec, v_fetch);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_reset_outs", 0, dut_vec, v_fetch);

    // Per-cycle vectors
    for (int i = 0; i < tbl.size(); i++) begin
      op = tbl[i].op; funct = tbl[i].funct; rd = tbl[i].rd;
      #1;
      chk("state", i, 16'(state_dbg), 16'(tbl[i].st));
      chk("outs", i, dut_vec, tbl[i].outs);
      chk("imm_reg_src", i, {12'h0, imm_src, reg_src},
          {12'h0, tbl[i].op, (tbl[i].op == 2'b01), (tbl[i].op == 2'b10)});
      @(negedge clk);
    end
    chk("back_to_fetch", 0, 16'(state_dbg), 16'(FETCH));

    // Latency per instruction class
    run_latency(2'b00, 6'b001000, 4);
    run_latency(2'b01, 6'b011001, 5);
    run_latency(2'b01, 6'b011000, 4);
    run_latency(2'b10, 6'b000000, 3);
    run_latency(2'b11, 6'b000000, 2);

    // Reset asserted while in MEMADR
    op = 2'b01; funct = 6'b011000; rd = 4'd2;
    @(negedge clk);
    @(negedge clk);
    chk("pre_reset_memadr", 0, 16'(state_dbg), 16'(MEMADR));
    #2 reset = 1'b1;
    #1;
    chk("async_reset_state", 0, 16'(state_dbg), 16'(FETCH));
    chk("async_reset_outs", 0, dut_vec, v_fetch);
    @(posedge clk);
    #1;
    chk("reset_held_outs", 0, {14'h0, ir_write, mem_w}, 16'h0002);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("release_state", 0, 16'(state_dbg), 16'(FETCH));
    @(posedge clk);
    #1;
    chk("first_edge_state", 0, 16'(state_dbg), 16'(DECODE));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
